// File: rtl/alu.sv
// 16-bit ALU: combinational operation select, results captured on the falling clk edge.
module alu (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [7:0]  op,
    input  logic        cf,
    output logic [15:0] acc,
    output logic [15:0] c,
    output logic        c_flag,
    output logic        z_flag,
    output logic        o_flag
);

    localparam int unsigned W = 16;

    localparam logic [7:0] OP_ADD  = 8'h01;
    localparam logic [7:0] OP_ADC  = 8'h02;
    localparam logic [7:0] OP_SUB  = 8'h03;
    localparam logic [7:0] OP_SUC  = 8'h04;
    localparam logic [7:0] OP_MUL8 = 8'h05;
    localparam logic [7:0] OP_MUL6 = 8'h06;
    localparam logic [7:0] OP_DIV8 = 8'h07;
    localparam logic [7:0] OP_DIV6 = 8'h08;
    localparam logic [7:0] OP_CMP  = 8'h09;
    localparam logic [7:0] OP_AND  = 8'h0A;
    localparam logic [7:0] OP_NEG  = 8'h0B;
    localparam logic [7:0] OP_NOT  = 8'h0C;
    localparam logic [7:0] OP_OR   = 8'h0D;
    localparam logic [7:0] OP_SHL  = 8'h0E;
    localparam logic [7:0] OP_SHR  = 8'h0F;
    localparam logic [7:0] OP_XOR  = 8'h10;
    localparam logic [7:0] OP_TEST = 8'h11;

    logic [W-1:0]   acc_q, acc_d;
    logic [W-1:0]   c_q, c_d;
    logic           cflag_q, cflag_d;
    logic           zflag_q, zflag_d;
    logic           oflag_q, oflag_d;

    logic           cin;
    logic [W:0]     sum;
    logic [W:0]     diff;
    logic [2*W-1:0] prod;
    logic [W-1:0]   quo16, rem16;
    logic [7:0]     quo8, rem8;

    // Shared arithmetic terms; carry-in only applies to ADC/SUC.
    always_comb begin
        cin   = (op == OP_ADC || op == OP_SUC) ? cf : 1'b0;
        sum   = (W+1)'(a) + (W+1)'(b) + (W+1)'(cin);
        diff  = (W+1)'(a) - (W+1)'(b) - (W+1)'(cin);
        prod  = (2*W)'(a) * (2*W)'(b);
        quo16 = (b != '0) ? a / b : '0;
        rem16 = (b != '0) ? a % b : '0;
        quo8  = (b[7:0] != 8'h00) ? a[7:0] / b[7:0] : 8'h00;
        rem8  = (b[7:0] != 8'h00) ? a[7:0] % b[7:0] : 8'h00;
    end

    // Result and flag selection for the value about to be registered.
    always_comb begin
        acc_d   = '0;
        c_d     = '0;
        cflag_d = 1'b0;
        oflag_d = 1'b0;
        unique case (op)
            OP_ADD, OP_ADC: begin
                acc_d   = sum[W-1:0];
                cflag_d = sum[W];
                oflag_d = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
            end
            OP_SUB, OP_SUC, OP_CMP: begin
                acc_d   = diff[W-1:0];
                cflag_d = diff[W];
                oflag_d = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
            end
            OP_MUL8: acc_d = (W)'(a[7:0]) * (W)'(b[7:0]);
            OP_MUL6: begin
                acc_d = prod[W-1:0];
                c_d   = prod[2*W-1:W];
            end
            OP_DIV8: begin
                if (b[7:0] == 8'h00) begin
                    acc_d   = '1;
                    c_d     = a;
                    oflag_d = 1'b1;
                end else begin
                    acc_d = {rem8, quo8};
                end
            end
            OP_DIV6: begin
                if (b == '0) begin
                    acc_d   = '1;
                    c_d     = a;
                    oflag_d = 1'b1;
                end else begin
                    acc_d = quo16;
                    c_d   = rem16;
                end
            end
            OP_AND, OP_TEST: acc_d = a & b;
            OP_OR:           acc_d = a | b;
            OP_XOR:          acc_d = a ^ b;
            OP_NOT:          acc_d = ~a;
            OP_NEG: begin
                acc_d   = '0 - a;
                cflag_d = (a != '0);
                oflag_d = (a == 16'h8000);
            end
            OP_SHL: begin
                acc_d   = {a[W-2:0], 1'b0};
                cflag_d = a[W-1];
            end
            OP_SHR: begin
                acc_d   = {1'b0, a[W-1:1]};
                cflag_d = a[0];
            end
            default: ;
        endcase
        zflag_d = (acc_d == '0);
    end

    // Falling-edge capture; reset clears everything immediately.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            acc_q   <= '0;
            c_q     <= '0;
            cflag_q <= 1'b0;
            zflag_q <= 1'b0;
            oflag_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            c_q     <= c_d;
            cflag_q <= cflag_d;
            zflag_q <= zflag_d;
            oflag_q <= oflag_d;
        end
    end

    assign acc    = acc_q;
    assign c      = c_q;
    assign c_flag = cflag_q;
    assign z_flag = zflag_q;
    assign o_flag = oflag_q;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu with hand-computed expectations.
module tb_alu;

    logic        clk;
    logic        reset;
    logic [15:0] a, b;
    logic [7:0]  op;
    logic        cf;
    logic [15:0] acc, c;
    logic        c_flag, z_flag, o_flag;

    int n_tests;
    int n_fail;

    alu dut (
        .clk    (clk),
        .reset  (reset),
        .a      (a),
        .b      (b),
        .op     (op),
        .cf     (cf),
        .acc    (acc),
        .c      (c),
        .c_flag (c_flag),
        .z_flag (z_flag),
        .o_flag (o_flag)
    );

    // 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports mismatches.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [15:0] e_acc, input logic [15:0] e_c,
                             input logic e_cf, input logic e_z, input logic e_o);
        check({tag, " acc"}, 32'(acc), 32'(e_acc));
        check({tag, " c"},   32'(c),   32'(e_c));
        check({tag, " cf"},  32'(c_flag), 32'(e_cf));
        check({tag, " zf"},  32'(z_flag), 32'(e_z));
        check({tag, " of"},  32'(o_flag), 32'(e_o));
    endtask

    // Apply after a rising edge, sample just after the next rising edge.
    task automatic run(input string tag, input logic [7:0] t_op, input logic [15:0] t_a,
                       input logic [15:0] t_b, input logic t_cf,
                       input logic [15:0] e_acc, input logic [15:0] e_c,
                       input logic e_cf, input logic e_z, input logic e_o);
        @(posedge clk);
        #1;
        op = t_op; a = t_a; b = t_b; cf = t_cf;
        @(posedge clk);
        #1;
        check_all(tag, e_acc, e_c, e_cf, e_z, e_o);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b1;
        a = 16'h5555; b = 16'h1111; op = 8'h01; cf = 1'b1;
        #1;
        check_all("por", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_all("por_hold", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        //   tag          op     a         b         cf    acc       c         cf    z     o
        run("add_wrap",  8'h01, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0);
        run("adc_wrap",  8'h02, 16'hFFFF, 16'h0001, 1'b1, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0);
        run("add_cf_ign",8'h01, 16'h0002, 16'h0003, 1'b1, 16'h0005, 16'h0000, 1'b0, 1'b0, 1'b0);
        run("add_ovf",   8'h01, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 16'h0000, 1'b0, 1'b0, 1'b1);
        run("sub_brw",   8'h03, 16'h0001, 16'h0002, 1'b0, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0);
        run("sub_ovf",   8'h03, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 16'h0000, 1'b0, 1'b0, 1'b1);
        run("suc",       8'h04, 16'h0005, 16'h0003, 1'b1, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0);
        run("suc_brw",   8'h04, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0);
        run("cmp_eq",    8'h09, 16'h0003, 16'h0003, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
        run("mul6",      8'h06, 16'h1234, 16'h0100, 1'b0, 16'h3400, 16'h0012, 1'b0, 1'b0, 1'b0);
        run("mul6_max",  8'h06, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0001, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        run("mul8",      8'h05, 16'h12FF, 16'h34FF, 1'b0, 16'hFE01, 16'h0000, 1'b0, 1'b0, 1'b0);
        run("div6",      8'h08, 16'h0007, 16'h0002, 1'b0, 16'h0003, 16'h0001, 1'b0, 1'b0, 1'b0);
        run("div6_zero", 8'h08, 16'hABCD, 16'h0000, 1'b0, 16'hFFFF, 16'hABCD, 1'b0, 1'b0, 1'b1);
        run("div8",      8'h07, 16'h0007, 16'h0002, 1'b0, 16'h0103, 16'h0000, 1'b0, 1'b0, 1'b0);
        run("div8_zero", 8'h07, 16'h1200, 16'h0100, 1'b0, 16'hFFFF, 16'h1200, 1'b0, 1'b0, 1'b1);
        run("and",       8'h0A, 16'hF0F0, 16'h3C3C, 1'b1, 16'h3030, 16'h0000, 1'b0, 1'b0, 1'b0);
        run("or",        8'h0D, 16'hF0F0, 16'h0F0F, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0);
        run("xor",       8'h10, 16'hAAAA, 16'hAAAA, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
        run("test",      8'h11, 16'h00FF, 16'hFF00, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
        run("not",       8'h0C, 16'h0000, 16'h1234, 1'b1, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0);
        run("neg_min",   8'h0B, 16'h8000, 16'h0000, 1'b0, 16'h8000, 16'h0000, 1'b1, 1'b0, 1'b1);
        run("neg_one",   8'h0B, 16'h0001, 16'hFFFF, 1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0);
        run("neg_zero",  8'h0B, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
        run("shl",       8'h0E, 16'h8001, 16'hFFFF, 1'b1, 16'h0002, 16'h0000, 1'b1, 1'b0, 1'b0);
        run("shr",       8'h0F, 16'h0003, 16'hFFFF, 1'b1, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0);
        run("op00",      8'h00, 16'h1234, 16'h5678, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
        run("op12",      8'h12, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
        run("opFF",      8'hFF, 16'h8000, 16'h0001, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a high clock phase.
        run("pre_rst",   8'h01, 16'h1200, 16'h0034, 1'b0, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check_all("rst_async", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #1;
        check_all("rst_hold", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        check_all("rst_rel", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        check_all("post_rst", 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
